muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Iterative unsigned multiply/divide sequencer for the RISC-V core's execute stage (M-extension subset: MUL, MULHU, DIVU, REMU). It owns no adder. Instead it borrows the core's shared 32-bit ALU one cycle at a time, issuing ADD or SUB on the ALU control lines and reading back the result. Valid/ready handshakes are used on both the operand side and the result side. A request/grant pair lets the pipeline control keep priority on the ALU.

Parameters:
XLEN, 32, operand and result width; must match the ALU width.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
IN_VALID  in  1  operands and op are valid.
IN_READY  out  1  block can accept an operation (high only in IDLE).
IN_OP  in  2  operation: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
IN_A  in  XLEN  multiplicand or dividend.
IN_B  in  XLEN  multiplier or divisor.
FLUSH  in  1  abort the current operation, return to IDLE.
ALU_REQ  out  1  requests the shared ALU for this cycle.
ALU_GNT  in  1  ALU is granted this cycle; the drive outputs below are used.
ALU_SRC_A  out  XLEN  ALU operand A.
ALU_SRC_B  out  XLEN  ALU operand B.
ALU_CONTROL  out  3  ALU opcode; only ALU_ADD or ALU_SUB is ever driven.
ALU_RES  in  XLEN  combinational ALU result for the current cycle.
OUT_VALID  out  1  result valid.
OUT_READY  in  1  consumer accepts the result.
OUT_RES  out  XLEN  result.

Behaviour:
- States are IDLE, BUSY and DONE.
- Reset values: state=IDLE, IN_READY=1, ALU_REQ=0, OUT_VALID=0, OUT_RES=0, ALU_SRC_A/B=0, ALU_CONTROL=ALU_ADD, counter=0, internal regs=0.
- IDLE:
  - IN_READY=1.
  - On IN_VALID, latch op, A and B.
  - Multiply: hi=0, lo=IN_B, mcand=IN_A.
  - Divide: rem=0, quo=IN_A, dvsr=IN_B.
  - Set cnt=0 and go to BUSY.
  - Divide with IN_B==0: go directly to DONE with OUT_RES = (DIVU ? all-ones : IN_A). This follows RISC-V semantics; ALU_REQ is never raised.
- BUSY:
  - ALU_REQ=1.
  - An iteration commits only in a cycle where ALU_GNT=1. With ALU_GNT=0, all state holds (stall). The ALU drive outputs are don't-care while ungranted.
- Multiply iteration:
  - Drive SRC_A=hi, SRC_B=mcand, CONTROL=ALU_ADD.
  - If lo[0]: sum=ALU_RES, carry=(ALU_RES < hi) as an unsigned compare, done locally. Otherwise sum=hi, carry=0.
  - Update {hi,lo} = {carry,sum,lo} >> 1.
- Divide iteration (restoring):
  - Shifted value r = {rem[XLEN-2:0], quo[XLEN-1]}; top = rem[XLEN-1].
  - Drive SRC_A=r, SRC_B=dvsr, CONTROL=ALU_SUB.
  - If top | (r >= dvsr): rem=ALU_RES and the new quo LSB is 1. Otherwise rem=r and the new quo LSB is 0.
  - quo is shifted left by one each iteration.
- Iteration count:
  - cnt increments per committed iteration.
  - After iteration XLEN (cnt==XLEN-1 committing), go to DONE.
  - OUT_RES is registered from lo (MUL), hi (MULHU), quo (DIVU) or rem (REMU).
- Latency: OUT_VALID rises exactly XLEN+1 cycles after the accept edge with no stalls, i.e. 33 cycles. Each ungranted BUSY cycle adds one. The divide-by-zero path gives OUT_VALID one cycle after accept.
- DONE:
  - OUT_VALID=1.
  - OUT_RES is held stable until OUT_VALID & OUT_READY, then go to IDLE. IN_READY is 0 during DONE, so there are no back-to-back accepts in the same cycle.
  - OUT_READY high on the first DONE cycle returns to IDLE on the next edge.
- FLUSH:
  - Highest priority among synchronous events.
  - In any state, the next state is IDLE and OUT_VALID is cleared. Any result not yet handed off is discarded.
  - FLUSH together with IN_VALID in IDLE: the request is not accepted.
- RESET asserted mid-operation immediately forces reset values, asynchronously.
- ALU_REQ is 0 in IDLE and DONE.
- Width rules:
  - Carry and the 33-bit compare are done locally with XLEN+1-bit arithmetic.
  - All adds and subtracts that produce stored values go through the ALU.

Decomposition:
- The ALU opcode constants ALU_ADD, ALU_SUB, ALU_AND and ALU_OR stay in the shared constants include.
- Add to the same include: the MULDIV_* op encodings (2-bit) and the state encoding (IDLE=0, BUSY=1, DONE=2).
- One natural sub-module, muldiv_step: combinational per-iteration next-state logic (ALU drive plus next hi/lo or rem/quo). It leaves the FSM, counter and handshakes in muldiv_seq.

Test Plan:
- MUL, A=7, B=6, GNT tied 1 -> OUT_VALID 33 cycles after accept, OUT_RES=42; ALU_CONTROL=ALU_ADD throughout BUSY.
- MULHU, A=B=0xFFFFFFFF -> OUT_RES=0xFFFFFFFE. Same operands with MUL -> 0x00000001.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 0x80000000/1 -> 0x80000000.
- DIVU 5/0 -> OUT_RES=0xFFFFFFFF and REMU 5/0 -> 5, both with OUT_VALID one cycle after accept and ALU_REQ never high.
- MUL 3*5 with ALU_GNT=0 on 10 scattered BUSY cycles -> result 15 at 43 cycles; OUT_READY held low 5 cycles -> OUT_VALID and OUT_RES stable, IN_READY=0 throughout.
- DIVU started, FLUSH at BUSY cycle 10 -> IDLE next cycle with IN_READY=1 and no OUT_VALID. A new MUL 2*2 then returns 4. RESET pulsed mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes, MULDIV op
// encodings and FSM state encoding.
package muldiv_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] MULDIV_MUL   = 2'b00;
  localparam logic [1:0] MULDIV_MULHU = 2'b01;
  localparam logic [1:0] MULDIV_DIVU  = 2'b10;
  localparam logic [1:0] MULDIV_REMU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // MULHU and REMU read the accumulator (hi/rem), MUL and DIVU the shift register (lo/quo).
  function automatic logic op_selects_acc(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration: ALU drive and next
// accumulator (hi/rem) and shift register (lo/quo) values.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] sh_i,
  input  logic [XLEN-1:0] opd_i,
  input  logic [XLEN-1:0] alu_res_i,
  output logic [XLEN-1:0] alu_src_a_o,
  output logic [XLEN-1:0] alu_src_b_o,
  output logic [2:0]      alu_ctrl_o,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] sh_o
);

  logic [XLEN-1:0] r_s;
  logic [XLEN-1:0] sum_s;
  logic            take_s;
  logic            carry_s;

  // Divide uses the remainder shifted left with the next dividend bit; the
  // dropped top bit forces a subtract because {top,r} then exceeds any divisor.
  always_comb begin
    r_s         = {acc_i[XLEN-2:0], sh_i[XLEN-1]};
    take_s      = 1'b0;
    carry_s     = 1'b0;
    sum_s       = acc_i;
    alu_src_b_o = opd_i;
    if (is_div_i) begin
      alu_src_a_o = r_s;
      alu_ctrl_o  = ALU_SUB;
      take_s      = acc_i[XLEN-1] | ({1'b0, r_s} >= {1'b0, opd_i});
      acc_o       = take_s ? alu_res_i : r_s;
      sh_o        = {sh_i[XLEN-2:0], take_s};
    end else begin
      alu_src_a_o = acc_i;
      alu_ctrl_o  = ALU_ADD;
      if (sh_i[0]) begin
        sum_s   = alu_res_i;
        carry_s = ({1'b0, alu_res_i} < {1'b0, acc_i});
      end else begin
        sum_s   = acc_i;
        carry_s = 1'b0;
      end
      acc_o = {carry_s, sum_s[XLEN-1:1]};
      sh_o  = {sum_s[0], sh_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the core's
// shared ALU one granted cycle at a time.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [1:0]      IN_OP,
  input  logic [XLEN-1:0] IN_A,
  input  logic [XLEN-1:0] IN_B,
  input  logic            FLUSH,
  output logic            ALU_REQ,
  input  logic            ALU_GNT,
  output logic [XLEN-1:0] ALU_SRC_A,
  output logic [XLEN-1:0] ALU_SRC_B,
  output logic [2:0]      ALU_CONTROL,
  input  logic [XLEN-1:0] ALU_RES,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_RES
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  sh_q, sh_d;
  logic [XLEN-1:0]  opd_q, opd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  out_res_q, out_res_d;

  logic [XLEN-1:0]  step_src_a_s, step_src_b_s, step_acc_s, step_sh_s;
  logic [2:0]       step_ctrl_s;
  logic             busy_s;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i    (op_q[1]),
    .acc_i       (acc_q),
    .sh_i        (sh_q),
    .opd_i       (opd_q),
    .alu_res_i   (ALU_RES),
    .alu_src_a_o (step_src_a_s),
    .alu_src_b_o (step_src_b_s),
    .alu_ctrl_o  (step_ctrl_s),
    .acc_o       (step_acc_s),
    .sh_o        (step_sh_s)
  );

  assign busy_s      = (state_q == ST_BUSY);
  assign IN_READY    = (state_q == ST_IDLE);
  assign OUT_VALID   = (state_q == ST_DONE);
  assign ALU_REQ     = busy_s;
  assign ALU_SRC_A   = busy_s ? step_src_a_s : {XLEN{1'b0}};
  assign ALU_SRC_B   = busy_s ? step_src_b_s : {XLEN{1'b0}};
  assign ALU_CONTROL = busy_s ? step_ctrl_s : ALU_ADD;
  assign OUT_RES     = out_res_q;

  // FSM, operand latch, iteration commit and result capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opd_d     = opd_q;
    cnt_d     = cnt_q;
    out_res_d = out_res_q;
    if (FLUSH) begin
      state_d   = ST_IDLE;
      out_res_d = {XLEN{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            op_d  = IN_OP;
            acc_d = {XLEN{1'b0}};
            sh_d  = IN_IS_MUL_SWAP(IN_OP, IN_A, IN_B);
            opd_d = IN_OP[1] ? IN_B : IN_A;
            cnt_d = {CNT_W{1'b0}};
            if (IN_OP[1] && (IN_B == {XLEN{1'b0}})) begin
              state_d   = ST_DONE;
              out_res_d = (IN_OP == MULDIV_DIVU) ? {XLEN{1'b1}} : IN_A;
            end else begin
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (ALU_GNT) begin
            acc_d = step_acc_s;
            sh_d  = step_sh_s;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_d   = ST_DONE;
              out_res_d = op_selects_acc(op_q) ? step_acc_s : step_sh_s;
            end else begin
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Multiply seeds lo with the multiplier; divide seeds quo with the dividend.
  function automatic logic [XLEN-1:0] IN_IS_MUL_SWAP(input logic [1:0] op,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
    return op[1] ? a : b;
  endfunction

  // State registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      acc_q     <= {XLEN{1'b0}};
      sh_q      <= {XLEN{1'b0}};
      opd_q     <= {XLEN{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      out_res_q <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opd_q     <= opd_d;
      cnt_q     <= cnt_d;
      out_res_q <= out_res_d;
    end
  end

endmodule
